pll_lock_sequencer: RTL

//  Sequences the reset of the on-chip PLL (50 MHz ref -> 4 MHz / 1 MHz NCO clocks) and qualifies its lock.

---
 rtl/pll_lock_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock qualification sequencer on the free-running reference clock.
// Optional build macro PLL_AUTO_RELOCK_EN: lock loss in RUN restarts the sequence instead of faulting.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 10,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       restart,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);

  // Terminal values are one below the parameter: the transition edge is the Nth cycle.
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STAB_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  logic          lock_meta;
  logic          locked_s;
  logic [PW-1:0] pulse_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] stab_cnt;

  logic pulse_clr, pulse_inc;
  logic tmo_clr, tmo_inc;
  logic stab_clr, stab_inc;
  logic retry_clr, retry_inc;

  logic pulse_done;
  logic timeout_hit;
  logic stable_done;
  logic retries_spent;

  assign state = cur_state;

  // locked is asynchronous to refclk
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= locked;
      locked_s  <= lock_meta;
    end
  end

  assign pulse_done    = (pulse_cnt == PULSE_LAST);
  assign timeout_hit   = (tmo_cnt == TMO_LAST);
  assign stable_done   = locked_s && (stab_cnt == STAB_LAST);
  assign retries_spent = (retry_cnt == RETRY_MAX);

  always_comb begin
    nxt_state = cur_state;
    pulse_clr = 1'b0;
    pulse_inc = 1'b0;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    stab_clr  = 1'b0;
    stab_inc  = 1'b0;
    retry_clr = 1'b0;
    retry_inc = 1'b0;

    if (restart) begin
      nxt_state = RESET_PLL;
      pulse_clr = 1'b1;
      tmo_clr   = 1'b1;
      stab_clr  = 1'b1;
      retry_clr = 1'b1;
    end else begin
      case (cur_state)
        RESET_PLL: begin
          tmo_clr  = 1'b1;
          stab_clr = 1'b1;
          if (pulse_done) begin
            nxt_state = WAIT_LOCK;
            pulse_clr = 1'b1;
          end else begin
            pulse_inc = 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (timeout_hit) begin
            pulse_clr = 1'b1;
            if (retries_spent) begin
              nxt_state = FAULT;
            end else begin
              nxt_state = RESET_PLL;
              retry_inc = 1'b1;
            end
          end else begin
            tmo_inc = 1'b1;
            if (locked_s) begin
              nxt_state = STABLE;
              stab_clr  = 1'b1;
            end
          end
        end

        STABLE: begin
          // Completion is checked before the timeout so a lock qualified on the last cycle is kept.
          if (stable_done) begin
            nxt_state = RUN;
            stab_clr  = 1'b1;
          end else if (timeout_hit) begin
            pulse_clr = 1'b1;
            stab_clr  = 1'b1;
            if (retries_spent) begin
              nxt_state = FAULT;
            end else begin
              nxt_state = RESET_PLL;
              retry_inc = 1'b1;
            end
          end else begin
            tmo_inc = 1'b1;
            if (locked_s) begin
              stab_inc = 1'b1;
            end else begin
              nxt_state = WAIT_LOCK;
              stab_clr  = 1'b1;
            end
          end
        end

        RUN: begin
          if (!locked_s) begin
`ifdef PLL_AUTO_RELOCK_EN
            nxt_state = RESET_PLL;
            pulse_clr = 1'b1;
            tmo_clr   = 1'b1;
            stab_clr  = 1'b1;
            retry_clr = 1'b1;
`else
            nxt_state = FAULT;
`endif
          end
        end

        FAULT: begin
          nxt_state = FAULT;
        end

        default: begin
          nxt_state = RESET_PLL;
          pulse_clr = 1'b1;
          tmo_clr   = 1'b1;
          stab_clr  = 1'b1;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      cur_state <= RESET_PLL;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      pll_rst   <= (nxt_state == RESET_PLL);
      sys_rst   <= (nxt_state != RUN);
      ready     <= (nxt_state == RUN);
      fault     <= (nxt_state == FAULT);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      pulse_cnt <= '0;
      tmo_cnt   <= '0;
      stab_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      if (pulse_clr) begin
        pulse_cnt <= '0;
      end else if (pulse_inc) begin
        pulse_cnt <= pulse_cnt + PW'(1);
      end

      if (tmo_clr) begin
        tmo_cnt <= '0;
      end else if (tmo_inc) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      if (stab_clr) begin
        stab_cnt <= '0;
      end else if (stab_inc) begin
        stab_cnt <= stab_cnt + SW'(1);
      end

      if (retry_clr) begin
        retry_cnt <= '0;
      end else if (retry_inc) begin
        retry_cnt <= retry_cnt + 4'd1;
      end
    end
  end

endmodule
